// File: rtl/mem_store_buffer.sv
// In-order store buffer between the MEM stage and the big-endian data memory. It drains the
// head entry whenever the write port is free and flags loads that overlap pending stores.
module mem_store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 9
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    input  logic [ADDR_W-1:0]          st_addr,
    input  logic [31:0]                st_data,
    input  logic [1:0]                 st_size,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [ADDR_W-1:0]          ld_addr,
    input  logic [1:0]                 ld_size,
    output logic                       ld_hazard,
    output logic [ADDR_W-1:0]          dm_A,
    output logic [31:0]                dm_DI,
    output logic [1:0]                 dm_Size,
    output logic                       dm_RW,
    output logic                       dm_E,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned RngW = ADDR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [1:0]        size_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PtrW-1:0]   head_q;
    logic [PtrW-1:0]   tail_q;
    logic [CntW-1:0]   count_q;
    logic              enq;
    logic              drain;
    logic              hit;
    logic [RngW-1:0]   ld_lo;
    logic [RngW-1:0]   ld_hi;

    function automatic logic [2:0] size_len(input logic [1:0] size);
        case (size)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            2'b10:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Ranges are one bit wider than the address so a store near the top of memory never wraps.
    always_comb begin
        ld_lo = {1'b0, ld_addr};
        ld_hi = ld_lo + RngW'(size_len(ld_size)) - RngW'(1);
        hit   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [RngW-1:0] e_lo;
            logic [RngW-1:0] e_hi;
            e_lo = {1'b0, addr_q[i]};
            e_hi = e_lo + RngW'(size_len(size_q[i])) - RngW'(1);
            if (valid_q[i] && (size_q[i] != 2'b11) && (ld_lo <= e_hi) && (e_lo <= ld_hi)) begin
                hit = 1'b1;
            end
        end
        ld_hazard = ld_valid && (ld_size != 2'b11) && hit;
    end

    // A hazarding load gives up the port so the overlapping entries can retire.
    always_comb begin
        st_ready = (count_q < CntW'(DEPTH));
        empty    = (count_q == '0);
        drain    = !empty && (!ld_valid || ld_hazard);
        enq      = st_valid && st_ready && (st_size != 2'b11);
        dm_RW    = drain;
        dm_E     = drain;
        count    = count_q;
        if (valid_q[head_q]) begin
            dm_A    = addr_q[head_q];
            dm_DI   = data_q[head_q];
            dm_Size = size_q[head_q];
        end else begin
            dm_A    = '0;
            dm_DI   = '0;
            dm_Size = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (drain) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PtrW'(1);
            end
            if (enq) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PtrW'(1);
            end
            case ({enq, drain})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload needs no reset; valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
            size_q[tail_q] <= st_size;
        end
    end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Bench for mem_store_buffer: a queue of pending stores is the reference model; a monitor
// checks occupancy, hazards and every memory write against it, and mirrors memory contents.
`timescale 1ns/1ps
module tb_mem_store_buffer;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 9;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic [1:0]        st_size;
    logic              st_ready;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [1:0]        ld_size;
    logic              ld_hazard;
    logic [ADDR_W-1:0] dm_A;
    logic [31:0]       dm_DI;
    logic [1:0]        dm_Size;
    logic              dm_RW;
    logic              dm_E;
    logic [CNT_W-1:0]  count;
    logic              empty;

    typedef struct {
        int          addr;
        logic [31:0] data;
        logic [1:0]  size;
    } st_t;

    st_t        exp_q[$];
    logic [7:0] mem [512];
    int         n_cmp = 0;
    int         n_bad = 0;

    mem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
        .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size), .ld_hazard(ld_hazard),
        .dm_A(dm_A), .dm_DI(dm_DI), .dm_Size(dm_Size), .dm_RW(dm_RW), .dm_E(dm_E),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int len_of(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : 0;
    endfunction

    function automatic bit model_hazard();
        int lo, hi;
        if (!ld_valid || len_of(ld_size) == 0) return 1'b0;
        lo = int'(ld_addr);
        hi = lo + len_of(ld_size) - 1;
        foreach (exp_q[i]) begin
            if (lo <= exp_q[i].addr + len_of(exp_q[i].size) - 1 && exp_q[i].addr <= hi)
                return 1'b1;
        end
        return 1'b0;
    endfunction

    // Big-endian: the lowest address receives the most significant byte of the access.
    task automatic mem_write(input int a, input logic [31:0] d, input logic [1:0] s);
        int n;
        n = len_of(s);
        for (int k = 0; k < n; k++) mem[(a + k) % 512] = d[8*(n-1-k) +: 8];
    endtask

    // Monitor: compares each cycle's outputs with the model, then applies the cycle's events.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                check("rst_st_ready", st_ready, 1);
                check("rst_ld_hazard", ld_hazard, 0);
                check("rst_dm_RW", dm_RW, 0);
                check("rst_dm_E", dm_E, 0);
                check("rst_empty", empty, 1);
                check("rst_count", count, 0);
                check("rst_dm_A", dm_A, 0);
                check("rst_dm_DI", dm_DI, 0);
                check("rst_dm_Size", dm_Size, 0);
            end else begin
                bit hz, dr, rdy;
                st_t e;
                hz  = model_hazard();
                rdy = exp_q.size() < DEPTH;
                dr  = exp_q.size() != 0 && (!ld_valid || hz);
                check("count", count, exp_q.size());
                check("empty", empty, exp_q.size() == 0);
                check("st_ready", st_ready, rdy);
                check("ld_hazard", ld_hazard, hz);
                check("dm_RW", dm_RW, dr);
                check("dm_E", dm_E, dr);
                if (exp_q.size() != 0) begin
                    check("head_A", dm_A, exp_q[0].addr);
                    check("head_DI", dm_DI, exp_q[0].data);
                    check("head_Size", dm_Size, exp_q[0].size);
                end else begin
                    check("idle_A", dm_A, 0);
                    check("idle_DI", dm_DI, 0);
                    check("idle_Size", dm_Size, 0);
                end
                if (dm_RW) mem_write(int'(dm_A), dm_DI, dm_Size);
                if (dr) void'(exp_q.pop_front());
                if (st_valid && rdy && st_size != 2'b11) begin
                    e.addr = int'(st_addr);
                    e.data = st_data;
                    e.size = st_size;
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic drive(input bit sv, input int sa, input logic [31:0] sd, input logic [1:0] ss,
                         input bit lv, input int la, input logic [1:0] ls);
        @(posedge clk);
        #1;
        st_valid = sv;
        st_addr  = ADDR_W'(sa);
        st_data  = sd;
        st_size  = ss;
        ld_valid = lv;
        ld_addr  = ADDR_W'(la);
        ld_size  = ls;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain_all();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            idle(1);
            cyc++;
        end
        check("drain_timeout", exp_q.size(), 0);
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        st_valid = 0; st_addr = 0; st_data = 0; st_size = 0;
        ld_valid = 0; ld_addr = 0; ld_size = 0;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        #1;
        check("init_count", count, 0);
        check("init_st_ready", st_ready, 1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Single word store, drained the cycle after it is accepted.
        drive(1, 'h010, 32'hDEADBEEF, 2, 0, 0, 0);
        #2 check("t1_st_ready", st_ready, 1);
        idle(1);
        #2 check("t1_count1", count, 1);
        check("t1_dm_RW", dm_RW, 1);
        check("t1_dm_A", dm_A, 'h010);
        check("t1_dm_Size", dm_Size, 2);
        idle(1);
        #2 check("t1_count0", count, 0);
        check("t1_mem", {mem['h10], mem['h11], mem['h12], mem['h13]}, 32'hDEADBEEF);

        // Fill while a non-overlapping load holds the port; fifth store is refused.
        for (int i = 0; i < 4; i++) drive(1, 'h40 + 4*i, 32'hA0A0_0000 + i, 2, 1, 'h100, 0);
        drive(1, 'h50, 32'h5555_5555, 2, 1, 'h100, 0);
        #2 check("t2_count", count, 4);
        check("t2_st_ready", st_ready, 0);
        drain_all();
        check("t2_mem", {mem['h4C], mem['h4D], mem['h4E], mem['h4F]}, 32'hA0A0_0003);

        // Overlapping load forces a drain and the hazard clears the next cycle.
        drive(1, 'h021, 32'h0000_1234, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 'h022, 0);
        #2 check("t3_hazard", ld_hazard, 1);
        check("t3_drain", dm_RW, 1);
        drive(0, 0, 0, 0, 1, 'h022, 0);
        #2 check("t3_hazard_clr", ld_hazard, 0);
        check("t3_mem", mem['h22], 8'h34);
        idle(1);

        // Adjacent load does not overlap and keeps the port.
        drive(1, 'h030, 32'h0BAD_F00D, 2, 1, 'h100, 0);
        drive(0, 0, 0, 0, 1, 'h034, 0);
        #2 check("t4_hazard", ld_hazard, 0);
        check("t4_no_drain", dm_RW, 0);
        drain_all();

        // Word at the top of memory: range extends past 0x1FF without wrapping to 0.
        drive(1, 'h1FE, 32'hCAFE_BABE, 2, 1, 'h100, 0);
        drive(0, 0, 0, 0, 1, 'h000, 0);
        #2 check("t5_no_wrap", ld_hazard, 0);
        drive(0, 0, 0, 0, 1, 'h1FF, 0);
        #2 check("t5_hazard", ld_hazard, 1);
        drain_all();

        // Reset in the middle of draining discards the remaining entries.
        for (int i = 0; i < 3; i++) drive(1, 'h80 + 4*i, 32'h7700_0000 + i, 2, 1, 'h100, 0);
        idle(1);
        #1 rst_n = 1'b0;
        #1 check("t6_dm_E", dm_E, 0);
        check("t6_count", count, 0);
        check("t6_empty", empty, 1);
        check("t6_st_ready", st_ready, 1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle(4);
        #2 check("t6_after_count", count, 0);

        // Invalid-size store is accepted but dropped.
        drive(1, 'h60, 32'h1111_2222, 2, 1, 'h100, 0);
        drive(1, 'h64, 32'h3333_4444, 3, 1, 'h100, 0);
        #2 check("t6_sz11_ready", st_ready, 1);
        idle(0);
        drive(0, 0, 0, 0, 1, 'h100, 0);
        #2 check("t6_sz11_count", count, 1);
        drain_all();

        // Random traffic, including simultaneous store and load.
        for (int i = 0; i < 400; i++) begin
            int hi_sel;
            hi_sel = $urandom_range(0, 7);
            drive($urandom_range(0, 1), (hi_sel == 0) ? $urandom_range(500, 511)
                                                      : $urandom_range(0, 40),
                  $urandom, 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 2) != 0),
                  (hi_sel == 1) ? $urandom_range(500, 511) : $urandom_range(0, 44),
                  2'($urandom_range(0, 3)));
        end
        drain_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
